// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
// Shared constants for the local-update / beacon path blocks.
//   DATA_W      : width of one stream word (2-bit header + 132-bit payload)
//   HDR_*       : header codes carried in word bits [DATA_W-1:DATA_W-2]
//   arb_state_t : packet arbiter state encoding
//   force_eop   : rewrites a word's header to end-of-packet
// -----------------------------------------------------------------------------
package lu_pkg;

  localparam int DATA_W = 134;

  localparam logic [1:0] HDR_SOP = 2'b01;
  localparam logic [1:0] HDR_EOP = 2'b10;
  localparam logic [1:0] HDR_MID = 2'b11;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    TRAN_S  = 2'd1,
    DRAIN_S = 2'd2
  } arb_state_t;

  function automatic logic [DATA_W-1:0] force_eop(input logic [DATA_W-1:0] i_word);
    force_eop = {HDR_EOP, i_word[DATA_W-3:0]};
  endfunction

endpackage

// File: rtl/lu_arb.sv
// -----------------------------------------------------------------------------
// lu_arb
// Packet-granular round-robin merge of two FWFT packet FIFOs into one stream.
// Port 0 is the local beacon report source, port 1 the network ingress source.
// Whole packets are popped from the granted source and forwarded one clock
// after each pop; packets longer than MAX_PKT_WORDS are cut short, marked
// for drop and the remainder is drained from the source without output.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_arb_pkt_rdy0/1          source holds at least one complete packet
//   in_arb_empty0/1            source FIFO empty
//   in_arb_data0/1   [133:0]   source head word (FWFT)
//   out_arb_rd0/1              pop strobe to source (combinational)
//   out_arb_data     [133:0]   merged stream word (registered)
//   out_arb_data_wr            out_arb_data valid this cycle
//   out_arb_data_valid         1 = keep packet, 0 = drop
//   out_arb_data_valid_wr      strobe for out_arb_data_valid
//   out_arb_busy               packet transfer or drain in progress
//   out_arb_err                one-cycle pulse on forced termination
// -----------------------------------------------------------------------------
module lu_arb
  import lu_pkg::*;
#(
  parameter logic [7:0] MAX_PKT_WORDS = 8'd128,
  parameter logic [7:0] LMID          = 8'd12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_arb_pkt_rdy0,
  input  logic              in_arb_empty0,
  input  logic [DATA_W-1:0] in_arb_data0,
  output logic              out_arb_rd0,
  input  logic              in_arb_pkt_rdy1,
  input  logic              in_arb_empty1,
  input  logic [DATA_W-1:0] in_arb_data1,
  output logic              out_arb_rd1,
  output logic [DATA_W-1:0] out_arb_data,
  output logic              out_arb_data_wr,
  output logic              out_arb_data_valid,
  output logic              out_arb_data_valid_wr,
  output logic              out_arb_busy,
  output logic              out_arb_err
);

  if (MAX_PKT_WORDS < 8'd2) begin : g_bad_max
    $error("lu_arb (module id %0d): MAX_PKT_WORDS must be in 2..255", LMID);
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_grant;
  logic              w_grant_nxt;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic [7:0]        r_word_cnt;
  logic [7:0]        w_word_cnt_nxt;
  logic [7:0]        w_cnt_inc;

  logic              w_src_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_head_eop;
  logic              w_pop;

  logic [DATA_W-1:0] w_data_nxt;
  logic              w_wr_nxt;
  logic              w_valid_nxt;
  logic              w_valid_wr_nxt;
  logic              w_err_nxt;

  logic [DATA_W-1:0] r_data_p1;
  logic              r_wr_p1;
  logic              r_valid_p1;
  logic              r_valid_wr_p1;
  logic              r_err_p1;

  // Granted source view; the pop is only ever issued to the latched grant.
  assign w_src_empty = r_grant ? in_arb_empty1 : in_arb_empty0;
  assign w_head      = r_grant ? in_arb_data1  : in_arb_data0;
  assign w_head_eop  = (w_head[DATA_W-1:DATA_W-2] == HDR_EOP);
  assign w_pop       = (r_state != IDLE_S) && !w_src_empty;
  assign w_cnt_inc   = r_word_cnt + 8'd1;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE_S;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_word_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_word_cnt_nxt   = r_word_cnt;
    case (r_state)
      IDLE_S: begin
        if (in_arb_pkt_rdy0 || in_arb_pkt_rdy1) begin
          // On a tie the port that did not win last time goes next;
          // a single requester always wins.
          if (in_arb_pkt_rdy0 && in_arb_pkt_rdy1) begin
            w_grant_nxt = ~r_last_grant;
          end else begin
            w_grant_nxt = in_arb_pkt_rdy1;
          end
          w_last_grant_nxt = w_grant_nxt;
          w_state_nxt      = TRAN_S;
        end
      end
      TRAN_S: begin
        if (w_pop) begin
          if (w_head_eop) begin
            w_word_cnt_nxt = 8'd0;
            w_state_nxt    = IDLE_S;
          end else if (w_cnt_inc == MAX_PKT_WORDS) begin
            w_word_cnt_nxt = 8'd0;
            w_state_nxt    = DRAIN_S;
          end else begin
            w_word_cnt_nxt = w_cnt_inc;
          end
        end
      end
      DRAIN_S: begin
        if (w_pop && w_head_eop) begin
          w_state_nxt = IDLE_S;
        end
      end
      default: begin
        w_state_nxt    = IDLE_S;
        w_word_cnt_nxt = 8'd0;
      end
    endcase
  end

  // ---- output decode: pop strobes and next output word ----
  always_comb begin
    out_arb_rd0    = w_pop && !r_grant;
    out_arb_rd1    = w_pop &&  r_grant;
    w_data_nxt     = '0;
    w_wr_nxt       = 1'b0;
    w_valid_nxt    = 1'b0;
    w_valid_wr_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    if ((r_state == TRAN_S) && w_pop) begin
      w_wr_nxt   = 1'b1;
      w_data_nxt = w_head;
      if (w_head_eop) begin
        w_valid_nxt    = 1'b1;
        w_valid_wr_nxt = 1'b1;
      end else if (w_cnt_inc == MAX_PKT_WORDS) begin
        // Truncated packet: close it with an EOP header and mark it for drop.
        w_data_nxt     = force_eop(w_head);
        w_valid_wr_nxt = 1'b1;
        w_err_nxt      = 1'b1;
      end
    end
  end

  // ---- output register: one clock from pop to stream ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1     <= '0;
      r_wr_p1       <= 1'b0;
      r_valid_p1    <= 1'b0;
      r_valid_wr_p1 <= 1'b0;
      r_err_p1      <= 1'b0;
    end else begin
      r_data_p1     <= w_data_nxt;
      r_wr_p1       <= w_wr_nxt;
      r_valid_p1    <= w_valid_nxt;
      r_valid_wr_p1 <= w_valid_wr_nxt;
      r_err_p1      <= w_err_nxt;
    end
  end

  assign out_arb_data          = r_data_p1;
  assign out_arb_data_wr       = r_wr_p1;
  assign out_arb_data_valid    = r_valid_p1;
  assign out_arb_data_valid_wr = r_valid_wr_p1;
  assign out_arb_err           = r_err_p1;
  assign out_arb_busy          = (r_state != IDLE_S);

endmodule

// File: doc/lu_arb.md
Name: lu_arb

Overview:
- Packet-granular round-robin arbiter that merges two 134-bit packet sources into the single stream feeding the local-update/beacon path.
- Port 0 is the locally generated beacon report source (LCM). Port 1 is the network ingress source.
- Both sources are first-word-fall-through (FWFT) FIFOs that signal when a complete packet is stored.
- The block pops whole packets and emits them in codebase stream format (data/wr plus a per-packet valid word). It also enforces a maximum packet length.

Parameters:
MAX_PKT_WORDS, 8'd128, words allowed per packet before forced termination (legal range 2..255)
LMID, 8'd12, module ID tag; not used in logic, kept for the management map

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_arb_pkt_rdy0  in  1  source 0 holds at least one complete packet
in_arb_empty0  in  1  source 0 FIFO empty
in_arb_data0  in  134  source 0 head word (FWFT); [133:132] 01=SOP, 10=EOP, 11=idle/mid
out_arb_rd0  out  1  pop source 0 (combinational)
in_arb_pkt_rdy1  in  1  as above, source 1
in_arb_empty1  in  1  as above, source 1
in_arb_data1  in  134  as above, source 1
out_arb_rd1  out  1  pop source 1 (combinational)
out_arb_data  out  134  merged stream word (registered)
out_arb_data_wr  out  1  out_arb_data is valid this cycle
out_arb_data_valid  out  1  1 = keep packet, 0 = drop
out_arb_data_valid_wr  out  1  strobe for out_arb_data_valid
out_arb_busy  out  1  transfer in progress
out_arb_err  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset (async, rst_n=0) drives all registered outputs to 0, state=IDLE_S, last_grant=1 (port 0 wins first), word_cnt=0.
- States: IDLE_S, TRAN_S, DRAIN_S.
- IDLE_S:
  - out_arb_data_wr=0 and both rd=0.
  - If either in_arb_pkt_rdy is 1: grant goes to the requester that is not last_grant when both request, otherwise to the single requester. Latch grant, set last_grant=grant, go to TRAN_S next cycle.
  - No pop occurs in the arbitration cycle.
- TRAN_S:
  - rd[grant] = !empty[grant]. The other rd is always 0.
  - Each pop registers the word to out_arb_data with out_arb_data_wr=1 one cycle later (latency 1 clk from pop to output).
  - Each pop increments word_cnt.
  - If empty goes high mid-packet, the output pauses (wr=0) with no loss and no duplication.
  - EOP (data[133:132]==2'b10) popped: on the same output cycle assert out_arb_data_valid=1 and out_arb_data_valid_wr=1, clear word_cnt, go to IDLE_S.
  - Overlength: popped word_cnt reaches MAX_PKT_WORDS without EOP.
    - That output word is sent with [133:132] forced to 2'b10, out_arb_data_valid=0, valid_wr=1, out_arb_err pulsed.
    - Then go to DRAIN_S.
- DRAIN_S:
  - Keep popping the granted source, with output wr=0, until its EOP is popped; then go to IDLE_S.
  - Drained words are never emitted.
- A single-word packet (SOP and EOP flags in the same word cannot coexist) is treated as an EOP-only word; it is forwarded with valid=1.
- out_arb_busy=1 in TRAN_S and DRAIN_S.
- Grant is held for the whole packet. in_arb_pkt_rdy changes mid-packet are ignored.
- Minimum inter-packet gap at the output is 1 idle cycle (the arbitration cycle).
- Fairness: with both sources saturated, packets alternate strictly 0,1,0,1.
- out_arb_data, wr and valid fields are 0 whenever wr/valid_wr is 0.
- Reset mid-packet aborts immediately. The partially read packet is not resumed; upstream FIFOs are reset on the same rst_n.

Decomposition:
- Package lu_pkg holds shared constants, used by lupdate and future blocks:
  - HDR_SOP=2'b01, HDR_EOP=2'b10, HDR_MID=2'b11
  - DATA_W=134
  - state encodings
- No sub-module: the single FSM plus counter is about 200 lines.

Test Plan:
- Source 0 only: one 6-word packet (SOP, 4 mid, EOP) -> rd0 high 6 cycles starting 1 cycle after rdy0. Output is 6 words, identical, each 1 cycle after its pop. valid=1/valid_wr=1 on the word-6 cycle. rd1 never asserted.
- Both sources saturated with 3-word packets, 8 packets each -> output order 0,1,0,1,...; exactly 1 idle cycle between packets; no word lost or duplicated.
- empty0 forced high for 3 cycles after word 2 of a 5-word packet -> output wr low for 3 cycles, then words 3-5 follow. Contents are unchanged.
- MAX_PKT_WORDS=4, 7-word packet on source 1:
  - Output is 4 words, the 4th with [133:132]=10, valid=0, valid_wr=1; err pulses once.
  - Words 5-7 are popped with no output; the next packet is arbitrated normally.
- rst_n low during word 3 of an 8-word packet -> all outputs 0 asynchronously. After release, state is IDLE_S and port 0 wins the first tie.
